// File: rtl/fifo_sched_pkg.sv
// Shared defaults, helper function and operation encoding for the FIFO access scheduler.
package fifo_sched_pkg;

  localparam int unsigned DEF_NREQ       = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: search starts at ptr and wraps modulo NREQ.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned IDX_W = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic        found;
    int unsigned cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_access_sched.sv
// Shares one FIFO push port among NREQ writers (round robin) and one reader,
// never pushing and popping together, with occupancy tracked locally.
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NREQ       = DEF_NREQ,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned CNT_W      = clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            wr_req,
  input  logic [NREQ*DATA_WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]            wr_gnt,
  input  logic                       rd_req,
  output logic                       rd_gnt,
  output logic                       rd_valid,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       fifo_push,
  output logic [DATA_WIDTH-1:0]      fifo_din,
  output logic                       fifo_pop,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic [CNT_W-1:0]           level
);

  localparam int unsigned IDX_W = (NREQ > 1) ? clog2(NREQ) : 1;

  op_t                   last_op, last_op_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]      win_idx;
  logic [NREQ-1:0]       arb_gnt;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  wr_elig, rd_elig, do_wr, do_rd;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (wr_req),
    .ptr (rr_ptr),
    .en  (do_wr),
    .gnt (arb_gnt),
    .idx (win_idx)
  );

  // On a conflict the op opposite to the last accepted one wins; rst masks both grants.
  always_comb begin
    wr_elig = (|wr_req) && (level < CNT_W'(DEPTH));
    rd_elig = rd_req && (level != '0);
    do_wr   = !rst && wr_elig && (!rd_elig || last_op == OP_READ);
    do_rd   = !rst && rd_elig && !do_wr;
    wr_gnt  = arb_gnt;
    rd_gnt  = do_rd;
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) win_data = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    last_op_nxt = last_op;
    rr_ptr_nxt  = rr_ptr;
    if (do_wr) begin
      last_op_nxt = OP_WRITE;
      rr_ptr_nxt  = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (do_rd) begin
      last_op_nxt = OP_READ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_op   <= OP_READ;
      rr_ptr    <= '0;
      level     <= '0;
      fifo_push <= 1'b0;
      fifo_pop  <= 1'b0;
      fifo_din  <= '0;
      rd_valid  <= 1'b0;
    end else begin
      last_op   <= last_op_nxt;
      rr_ptr    <= rr_ptr_nxt;
      fifo_push <= do_wr;
      fifo_pop  <= do_rd;
      rd_valid  <= fifo_pop;
      if (do_wr) begin
        fifo_din <= win_data;
        level    <= level + CNT_W'(1);
      end else if (do_rd) begin
        level    <= level - CNT_W'(1);
      end
    end
  end

  assign rd_data = fifo_dout;

endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched: queue-based reference model, emulated FIFO,
// directed boundary scenarios plus randomized traffic with async resets.
module tb_fifo_access_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    wr_req, wr_gnt;
  logic [N*DW-1:0] wr_data;
  logic            rd_req, rd_gnt, rd_valid;
  logic [DW-1:0]   rd_data, fifo_din, fifo_dout;
  logic            fifo_push, fifo_pop;
  logic [CW-1:0]   level;

  always #5 clk = ~clk;

  fifo_access_sched #(
    .NREQ       (N),
    .DATA_WIDTH (DW),
    .DEPTH      (D),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .fifo_push (fifo_push),
    .fifo_din  (fifo_din),
    .fifo_pop  (fifo_pop),
    .fifo_dout (fifo_dout),
    .level     (level)
  );

  // Attached FIFO: registered dout, pop dropped when it coincides with a push.
  logic [DW-1:0] fq[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_dout <= '0;
    end else begin
      if (fifo_push && fq.size() < D) fq.push_back(fifo_din);
      if (fifo_pop && !fifo_push && fq.size() > 0) fifo_dout <= fq.pop_front();
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int            m_lvl, m_rr;
  bit            m_lastw;
  logic [DW-1:0] mq[$];
  bit            e_push, e_pop, e_valid;
  logic [DW-1:0] e_din, e_rdata, pipe_word;

  // Values sampled by the most recent step
  logic [N-1:0]  s_wgnt;
  logic          s_rgnt, s_push, s_valid;
  logic [DW-1:0] s_din, s_rdata;
  logic [CW-1:0] s_level;

  task automatic model_reset();
    m_lvl = 0; m_rr = 0; m_lastw = 1'b0;
    mq.delete();
    e_push = 0; e_pop = 0; e_valid = 0;
    e_din = '0; e_rdata = '0; pipe_word = '0;
  endtask

  task automatic predict(output int wk, output bit rg);
    bit we, re, takew;
    wk = -1;
    we = (wr_req != '0) && (m_lvl < D);
    re = rd_req && (m_lvl > 0);
    takew = we && (!re || !m_lastw);
    if (takew) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (wk < 0 && wr_req[c]) wk = c;
      end
    end
    rg = re && !takew;
  endtask

  task automatic step(input logic [N-1:0] wq, input logic [N*DW-1:0] wd, input logic rq);
    int       wk;
    bit       rg;
    logic [N-1:0] eg;
    @(negedge clk);
    wr_req = wq; wr_data = wd; rd_req = rq;
    #1;
    predict(wk, rg);
    eg = (wk >= 0) ? N'(1 << wk) : '0;
    chk("wr_gnt", wr_gnt, eg);
    chk("rd_gnt", rd_gnt, rg);
    chk("fifo_push", fifo_push, e_push);
    chk("fifo_pop", fifo_pop, e_pop);
    if (e_push) chk("fifo_din", fifo_din, e_din);
    chk("rd_valid", rd_valid, e_valid);
    if (e_valid) chk("rd_data", rd_data, e_rdata);
    chk("level", level, m_lvl);
    chk("push_pop_excl", fifo_push & fifo_pop, 0);
    s_wgnt = wr_gnt; s_rgnt = rd_gnt; s_push = fifo_push; s_din = fifo_din;
    s_valid = rd_valid; s_rdata = rd_data; s_level = level;
    @(posedge clk);
    e_valid = e_pop;
    e_rdata = pipe_word;
    e_push = 0; e_pop = 0;
    if (wk >= 0) begin
      e_push = 1; e_din = wd[wk*DW +: DW];
      mq.push_back(e_din);
      m_lvl++; m_lastw = 1'b1; m_rr = (wk + 1) % N;
    end
    if (rg) begin
      e_pop = 1; pipe_word = mq.pop_front();
      m_lvl--; m_lastw = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_req = '0; rd_req = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst_wr_gnt", wr_gnt, 0);
    chk("arst_rd_gnt", rd_gnt, 0);
    chk("arst_push", fifo_push, 0);
    chk("arst_pop", fifo_pop, 0);
    chk("arst_din", fifo_din, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_level", level, 0);
    model_reset();
    wr_req = '0; rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0]    g[10];
    logic [DW-1:0]   got[$];
    logic [N-1:0]    pend;
    logic [N*DW-1:0] pdat;
    logic [DW-1:0]   w;
    string           seq;
    int              cnt;
    rst = 1'b1; wr_req = '0; wr_data = '0; rd_req = 1'b0;
    #1;
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_push", fifo_push, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_level", level, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Single write from writer 2
    step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b0);
    chk("t1_gnt", s_wgnt, 4'b0100);
    step(4'b0000, '0, 1'b0);
    chk("t1_push", s_push, 1);
    chk("t1_din", s_din, 8'hA5);
    chk("t1_level", s_level, 1);

    // Round robin fill, then full boundary
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0);
      g[i] = s_wgnt;
      if (i == 8) chk("rr_full_level", s_level, 8);
    end
    chk("rr_g0", g[0], 4'b0001);
    chk("rr_g1", g[1], 4'b0010);
    chk("rr_g2", g[2], 4'b0100);
    chk("rr_g3", g[3], 4'b1000);
    chk("rr_g4", g[4], 4'b0001);
    chk("rr_full_g8", g[8], 4'b0000);
    chk("rr_full_g9", g[9], 4'b0000);
    step(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
    chk("full_rd_first", s_rgnt, 1);
    chk("full_wr_blocked", s_wgnt, 4'b0000);
    step(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
    chk("full_wr_next", s_wgnt, 4'b0001);

    // Fill with 10..17 then drain in order
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 8; i++) begin
      w = 8'h10 + DW'(cnt);
      step(4'b0001, {24'h0, w}, 1'b0);
      if (s_wgnt[0]) cnt++;
    end
    got.delete();
    for (int i = 0; i < 14; i++) begin
      step(4'b0000, '0, 1'b1);
      if (s_valid) got.push_back(s_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, '0, 1'b0);
      if (s_valid) got.push_back(s_rdata);
    end
    chk("drain_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_word", got[i], 8'h10 + i);
    chk("drain_level", s_level, 0);

    // Contention at level 4 with last op READ
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0001, {24'h0, 8'hC0 + DW'(i)}, 1'b0);
    step(4'b0000, '0, 1'b1);
    seq = "";
    for (int i = 0; i < 8; i++) begin
      step(4'b0010, {16'h0, 8'h77, 8'h0}, 1'b1);
      if (i > 0) chk("cont_level_osc", s_level, (i % 2 == 1) ? 5 : 4);
      seq = {seq, (s_wgnt != '0) ? "W" : (s_rgnt ? "R" : "-")};
    end
    chk("cont_seq_W", (seq == "WRWRWRWR") ? 1 : 0, 1);

    // Empty boundary: write first, read next, returns the word
    do_reset();
    step(4'b0001, {24'h0, 8'h3C}, 1'b1);
    chk("empty_wr_first", s_wgnt, 4'b0001);
    chk("empty_rd_blocked", s_rgnt, 0);
    step(4'b0001, {24'h0, 8'h5A}, 1'b1);
    chk("empty_rd_next", s_rgnt, 1);
    chk("empty_wr_held", s_wgnt, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, '0, 1'b0);
      if (s_valid) begin
        cnt++;
        chk("empty_rdata", s_rdata, 8'h3C);
      end
    end
    chk("empty_valid_cnt", cnt, 1);

    // Async reset during alternating traffic, then first conflict goes to write
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1010, {8'h91, 8'h0, 8'h92, 8'h0}, 1'b1);
    async_reset();
    step(4'b0001, {24'h0, 8'hE1}, 1'b1);
    chk("post_rst_wr", s_wgnt, 4'b0001);
    step(4'b0110, {8'h0, 8'hE3, 8'hE2, 8'h0}, 1'b1);
    chk("post_rst_rd", s_rgnt, 1);
    step(4'b0110, {8'h0, 8'hE3, 8'hE2, 8'h0}, 1'b1);
    chk("post_rst_rr", s_wgnt, 4'b0010);

    // Randomized traffic with held requests and occasional async reset
    do_reset();
    pend = '0; pdat = '0;
    for (int c = 0; c < 900; c++) begin
      int ph, pw, pr;
      ph = (c / 150) % 3;
      pw = (ph == 0) ? 70 : ((ph == 1) ? 15 : 45);
      pr = (ph == 0) ? 20 : ((ph == 1) ? 80 : 50);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < pw) begin
          pend[i] = 1'b1;
          pdat[i*DW +: DW] = DW'($urandom);
        end
      end
      step(pend, pdat, ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0);
      pend = pend & ~s_wgnt;
      if (c % 173 == 100) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
